uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single `uart_transmitter` between two byte requesters. It arbitrates round-robin, loads the winner's byte and baud setting into the transmitter, and issues the `Tx_WR` strobe. It then tracks `Tx_BUSY` through the frame and reports completion or a start timeout back to the granted requester. It sits directly in front of `uart_transmitter` and drives all of its control inputs.

## Interface
- `BUSY_TIMEOUT`, 16: cycles to wait for `Tx_BUSY` to rise after `Tx_WR` before aborting; legal range 2..255.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  global transmit enable.
- `req0` / `req1`  in  1  byte request from requester 0 / 1; level.
- `data0` / `data1`  in  8  byte to send; valid while the matching `req` is high.
- `baud0` / `baud1`  in  3  `baud_select` code for that requester's frame.
- `ack0` / `ack1`  out  1  1-cycle pulse: byte and baud latched.
- `done0` / `done1`  out  1  1-cycle pulse: frame fully transmitted.
- `timeout_err`  out  1  1-cycle pulse: `Tx_BUSY` never rose.
- `Tx_DATA`  out  8  byte to the transmitter.
- `baud_select`  out  3  baud code to the transmitter.
- `Tx_WR`  out  1  write strobe to the transmitter.
- `Tx_EN`  out  1  transmitter enable.
- `Tx_BUSY`  in  1  transmitter busy flag.

## Operation
- All outputs are registered.
- Reset values:
  - `Tx_DATA`=0, `baud_select`=0, `Tx_WR`=0, `Tx_EN`=0.
  - `ack*`=0, `done*`=0, `timeout_err`=0.
  - state IDLE, `last_grant`=1, timeout counter 0.
- `Tx_EN` is `enable` delayed by one register.
- **IDLE**: grants when `enable`=1, `Tx_BUSY`=0 and at least one `req` is high.
  - Single requester: that one wins.
  - Both requesting: the winner is the requester other than `last_grant`.
  - On grant, latch `data`/`baud` into `Tx_DATA`/`baud_select`, pulse the winner's `ack`, set `last_grant`=winner, go to SETUP.
- **SETUP**: one cycle so `baud_select` is stable before the strobe; go to WRITE.
- **WRITE**: `Tx_WR`=1 for exactly this cycle; clear the counter; go to WAIT_BUSY.
- **WAIT_BUSY**:
  - `Tx_BUSY`=1: go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`-1, pulse `timeout_err` and go to IDLE; no `done` is issued.
- **WAIT_DONE**: on `Tx_BUSY`=0, pulse the granted requester's `done` and go to IDLE.
- `Tx_DATA` and `baud_select` hold their values from grant until the next grant, and never change while `Tx_BUSY`=1.
- `req` still high when the arbiter returns to IDLE is a new request. Requesters drop `req` on `ack`.
- `enable` falling in any non-IDLE state:
  - Go to IDLE next cycle.
  - No `done` and no `timeout_err`.
  - `last_grant` is kept.
- `req` falling after grant has no effect; the latched byte is sent.
- Grants are never made while `enable`=0 or `Tx_BUSY`=1 in IDLE.
- Reset asserted mid-frame forces all reset values asynchronously.

## Timing
Cycle numbering starts at edge E, where IDLE samples `req`.
- E+1: `ack` = 1; `Tx_DATA` and `baud_select` valid; state SETUP.
- E+2: `Tx_WR` = 1; state WRITE.
- E+3: `Tx_WR` = 0; state WAIT_BUSY.
- If `Tx_BUSY` is first sampled high at edge B, state is WAIT_DONE at B+1.
- If `Tx_BUSY` is first sampled low at edge F in WAIT_DONE, `done` = 1 at F+1.
- IDLE holds at F+1, so the earliest next `ack` is at F+2.
- Minimum arbiter overhead per frame: 4 cycles outside `Tx_BUSY`.
- Timeout: `timeout_err` pulses `BUSY_TIMEOUT` cycles after `Tx_WR` deasserts, if `Tx_BUSY` stays low.
- `ack`, `done` and `timeout_err` are mutually exclusive in any cycle. Only one requester's signals ever pulse at a time.

## Test plan
- **Reset defaults**: hold `reset`=0 for 100 ns, then release with `enable`=0 and `req0`=1 → all outputs at reset values, no `ack0`, `Tx_EN`=0.
- **Single send**: `enable`=1, `req0`=1, `data0`=8'hAA, `baud0`=3'b111 → `ack0` at E+1. `Tx_DATA`=8'hAA and `baud_select`=7 from E+1. `Tx_WR` high one cycle at E+2. `done0` one cycle after the `Tx_BUSY` falling edge.
- **Contention**: `req0` and `req1` both high from reset, `data0`=8'h55, `data1`=8'hAA, `baud1`=3'b110 → requester 0 is granted first. After `done0`, requester 1 is granted with `baud_select`=6, and `baud_select` never changes while `Tx_BUSY`=1. Alternation continues with both requests held.
- **Timeout**: tie `Tx_BUSY`=0 with `BUSY_TIMEOUT`=16 → `timeout_err` pulses exactly 16 cycles after `Tx_WR` falls. No `done0`. State returns to IDLE and re-grants if `req0` is still high.
- **Abort**: drop `enable` in WAIT_DONE → `Tx_EN`=0 one cycle later, state IDLE, no `done`.
- **Reset mid-frame**: assert `reset` during WAIT_DONE → all outputs at reset values; after release requester 0 wins a simultaneous request.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_transmitter between two requesters.
// Loads byte/baud, strobes Tx_WR and tracks Tx_BUSY to completion or timeout.
`timescale 1ns/1ps
module uart_tx_arbiter #(
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [2:0] baud0,
    input  logic [2:0] baud1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic       timeout_err,
    output logic [7:0] Tx_DATA,
    output logic [2:0] baud_select,
    output logic       Tx_WR,
    output logic       Tx_EN,
    input  logic       Tx_BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRITE,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic [2:0] baud_q, baud_d;
    logic       wr_q, wr_d;
    logic       en_q;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       done0_q, done0_d;
    logic       done1_q, done1_d;
    logic       to_q, to_d;
    logic       win;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        baud_d  = baud_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        to_d    = 1'b0;
        win     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !Tx_BUSY && (req0 || req1)) begin
                    // Under contention the previous winner yields
                    win     = (req0 && req1) ? ~last_q : req1;
                    last_d  = win;
                    data_d  = win ? data1 : data0;
                    baud_d  = win ? baud1 : baud0;
                    ack0_d  = ~win;
                    ack1_d  = win;
                    state_d = SETUP;
                end
            end
            SETUP: state_d = WRITE;
            WRITE: begin
                cnt_d   = 8'd0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (Tx_BUSY) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!Tx_BUSY) begin
                    done0_d = ~last_q;
                    done1_d = last_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Disable aborts silently; the grant history is kept
        if (!enable && state_q != IDLE) begin
            state_d = IDLE;
            done0_d = 1'b0;
            done1_d = 1'b0;
            to_d    = 1'b0;
        end
        wr_d = (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            data_q  <= 8'd0;
            baud_q  <= 3'd0;
            wr_q    <= 1'b0;
            en_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            baud_q  <= baud_d;
            wr_q    <= wr_d;
            en_q    <= enable;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            to_q    <= to_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign done0       = done0_q;
    assign done1       = done1_q;
    assign timeout_err = to_q;
    assign Tx_DATA     = data_q;
    assign baud_select = baud_q;
    assign Tx_WR       = wr_q;
    assign Tx_EN       = en_q;

endmodule
